// File: rtl/mc_route_split_if.sv
// Request and route-beat bundle between the VC buffer head, the route/split stage and the switch allocator.
// Widths follow the mesh size so the stage and its neighbours agree on NODES and AW.
interface mc_route_split_if #(
    parameter int XSIZE = 5,
    parameter int YSIZE = 4
);
    localparam int NODES = XSIZE * YSIZE;
    localparam int AW    = $clog2(NODES);

    logic             in_valid;
    logic             in_ready;
    logic             in_um_type;
    logic [AW-1:0]    in_addr0;
    logic [NODES-1:0] in_addr1;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_port;
    logic [NODES-1:0] out_dests;
    logic             out_um_type;
    logic             out_last;
    logic             out_err;

    modport master (
        output in_valid, in_um_type, in_addr0, in_addr1, out_ready,
        input  in_ready, out_valid, out_port, out_dests, out_um_type, out_last, out_err
    );

    modport slave (
        input  in_valid, in_um_type, in_addr0, in_addr1, out_ready,
        output in_ready, out_valid, out_port, out_dests, out_um_type, out_last, out_err
    );
endinterface

// File: rtl/mc_route_split.sv
// Route compute and multicast split: groups a head flit's destinations by output port
// (XY or YX dimension order) and emits one route beat per non-empty port, lowest port first.
module mc_route_split #(
    parameter int XSIZE   = 5,
    parameter int YSIZE   = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    parameter int ROUTING = 0
) (
    input  logic            clk,
    input  logic            rst,
    mc_route_split_if.slave bus
);
    localparam int NODES = XSIZE * YSIZE;
    localparam int AW    = $clog2(NODES);

    typedef enum logic {IDLE, EMIT} state_t;

    // Port numbering: 0 Local, 1 East, 2 West, 3 North, 4 South.
    function automatic logic [2:0] port_of(input int x, input int y);
        logic [2:0] p;
        p = 3'd0;
        if (ROUTING == 0) begin
            if (x != MY_XPOS)      p = (x > MY_XPOS) ? 3'd1 : 3'd2;
            else if (y != MY_YPOS) p = (y > MY_YPOS) ? 3'd3 : 3'd4;
        end else begin
            if (y != MY_YPOS)      p = (y > MY_YPOS) ? 3'd3 : 3'd4;
            else if (x != MY_XPOS) p = (x > MY_XPOS) ? 3'd1 : 3'd2;
        end
        return p;
    endfunction

    logic [2:0] port_tab [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_tab
            assign port_tab[gi] = port_of(gi / YSIZE, gi % YSIZE);
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [4:0][NODES-1:0]   mask_q, mask_d;
    logic                    um_q, um_d;
    logic                    err_q, err_d;

    logic [NODES-1:0]        req_mask;
    logic [4:0][NODES-1:0]   cap_mask;
    logic [4:0]              nonempty;
    logic [4:0]              rest;
    logic [2:0]              sel;
    logic                    found;
    logic                    is_last;

    // Unicast becomes a one-hot mask; an out-of-range address matches no bit and yields zero.
    always_comb begin
        req_mask = '0;
        cap_mask = '0;
        for (int i = 0; i < NODES; i++) begin
            if (bus.in_um_type) req_mask[i] = bus.in_addr1[i];
            else                req_mask[i] = (bus.in_addr0 == AW'(i));
        end
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < NODES; i++) begin
                cap_mask[p][i] = req_mask[i] && (port_tab[i] == 3'(p));
            end
        end
    end

    always_comb begin
        sel   = 3'd0;
        found = 1'b0;
        for (int p = 0; p < 5; p++) begin
            nonempty[p] = |mask_q[p];
        end
        for (int p = 0; p < 5; p++) begin
            if (!found && nonempty[p]) begin
                sel   = 3'(p);
                found = 1'b1;
            end
        end
        rest    = nonempty & ~(5'b00001 << sel);
        is_last = found && (rest == 5'b00000);
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        um_d    = um_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (|req_mask) begin
                        mask_d  = cap_mask;
                        um_d    = bus.in_um_type;
                        state_d = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    mask_d[sel] = '0;
                    if (is_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            um_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            um_q    <= um_d;
            err_q   <= err_d;
        end
    end

    // Outputs come from flops only; reset masks them so nothing leaks out during the reset cycle.
    always_comb begin
        bus.in_ready    = (state_q == IDLE) && !rst;
        bus.out_valid   = (state_q == EMIT) && !rst;
        bus.out_port    = rst ? 3'd0 : sel;
        bus.out_dests   = rst ? '0 : mask_q[sel];
        bus.out_um_type = um_q && !rst;
        bus.out_last    = (state_q == EMIT) && is_last && !rst;
        bus.out_err     = err_q && !rst;
    end
endmodule

// File: tb/tb_mc_route_split.sv
// Directed checks of mc_route_split at node (1,1) of a 5x4 mesh, one XY and one YX instance.
module tb_mc_route_split;
    logic clk;
    logic rst;

    mc_route_split_if #(.XSIZE(5), .YSIZE(4)) if_xy ();
    mc_route_split_if #(.XSIZE(5), .YSIZE(4)) if_yx ();

    mc_route_split #(.XSIZE(5), .YSIZE(4), .MY_XPOS(1), .MY_YPOS(1), .ROUTING(0))
        u_xy (.clk(clk), .rst(rst), .bus(if_xy));
    mc_route_split #(.XSIZE(5), .YSIZE(4), .MY_XPOS(1), .MY_YPOS(1), .ROUTING(1))
        u_yx (.clk(clk), .rst(rst), .bus(if_yx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             um;
        logic [4:0]       a0;
        logic [19:0]      a1;
        int               sel;   // 0 = XY instance, 1 = YX instance
        int               nb;    // 0 = expect out_err
        logic [3:0][2:0]  p;
        logic [3:0][19:0] d;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  p;
        logic [19:0] d;
        logic        um;
        logic        last;
        logic        err;
        logic        rdy;
    } out_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs [12];

    function automatic vec_t mk(input logic um, input logic [4:0] a0, input logic [19:0] a1,
                                input int sel, input int nb,
                                input logic [2:0] p0, input logic [19:0] d0,
                                input logic [2:0] p1, input logic [19:0] d1,
                                input logic [2:0] p2, input logic [19:0] d2,
                                input logic [2:0] p3, input logic [19:0] d3);
        vec_t v;
        v.um = um; v.a0 = a0; v.a1 = a1; v.sel = sel; v.nb = nb;
        v.p[0] = p0; v.d[0] = d0; v.p[1] = p1; v.d[1] = d1;
        v.p[2] = p2; v.d[2] = d2; v.p[3] = p3; v.d[3] = d3;
        return v;
    endfunction

    function automatic out_t samp(input int sel);
        out_t o;
        if (sel == 0) o = '{if_xy.out_valid, if_xy.out_port, if_xy.out_dests, if_xy.out_um_type,
                            if_xy.out_last, if_xy.out_err, if_xy.in_ready};
        else          o = '{if_yx.out_valid, if_yx.out_port, if_yx.out_dests, if_yx.out_um_type,
                            if_yx.out_last, if_yx.out_err, if_yx.in_ready};
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_xy.in_um_type = v.um; if_xy.in_addr0 = v.a0; if_xy.in_addr1 = v.a1;
        if_yx.in_um_type = v.um; if_yx.in_addr0 = v.a0; if_yx.in_addr1 = v.a1;
        if_xy.in_valid = (v.sel == 0);
        if_yx.in_valid = (v.sel == 1);
    endtask

    task automatic idle_in();
        if_xy.in_valid = 1'b0;
        if_yx.in_valid = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        if_xy.out_ready = r;
        if_yx.out_ready = r;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        out_t o;
        @(negedge clk);
        drive(v);
        set_ready(1'b1);
        @(negedge clk);
        idle_in();
        if (v.nb == 0) begin
            o = samp(v.sel);
            chk($sformatf("v%0d_err", idx), 32'(o.err), 32'd1);
            chk($sformatf("v%0d_err_valid", idx), 32'(o.v), 32'd0);
            chk($sformatf("v%0d_err_ready", idx), 32'(o.rdy), 32'd1);
            @(negedge clk);
            o = samp(v.sel);
            chk($sformatf("v%0d_err_pulse_end", idx), 32'(o.err), 32'd0);
            chk($sformatf("v%0d_err_no_valid", idx), 32'(o.v), 32'd0);
        end else begin
            for (int b = 0; b < v.nb; b++) begin
                o = samp(v.sel);
                $display("v%0d beat%0d port=%0d dests=0x%05h last=%0d", idx, b, o.p, o.d, o.last);
                chk($sformatf("v%0d_b%0d_valid", idx, b), 32'(o.v), 32'd1);
                chk($sformatf("v%0d_b%0d_port", idx, b), 32'(o.p), 32'(v.p[b]));
                chk($sformatf("v%0d_b%0d_dests", idx, b), 32'(o.d), 32'(v.d[b]));
                chk($sformatf("v%0d_b%0d_um", idx, b), 32'(o.um), 32'(v.um));
                chk($sformatf("v%0d_b%0d_last", idx, b), 32'(o.last), 32'(b == v.nb - 1));
                chk($sformatf("v%0d_b%0d_inready", idx, b), 32'(o.rdy), 32'd0);
                @(negedge clk);
            end
            o = samp(v.sel);
            chk($sformatf("v%0d_done_valid", idx), 32'(o.v), 32'd0);
            chk($sformatf("v%0d_done_ready", idx), 32'(o.rdy), 32'd1);
        end
    endtask

    initial begin
        out_t o;
        // Destinations at node (1,1): index = x*4 + y, own index 5.
        vecs[0]  = mk(1'b1, 5'd0,  20'h02064, 0, 4, 3'd0, 20'h00020, 3'd1, 20'h02000,
                      3'd2, 20'h00004, 3'd3, 20'h00040);
        vecs[1]  = mk(1'b1, 5'd0,  20'h02064, 1, 3, 3'd0, 20'h00020, 3'd1, 20'h02000,
                      3'd3, 20'h00044, 3'd0, 20'h0);
        vecs[2]  = mk(1'b0, 5'd19, 20'h0,     0, 1, 3'd1, 20'h80000, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[3]  = mk(1'b0, 5'd5,  20'h0,     0, 1, 3'd0, 20'h00020, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[4]  = mk(1'b0, 5'd20, 20'hFFFFF, 0, 0, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[5]  = mk(1'b1, 5'd5,  20'h0,     0, 0, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[6]  = mk(1'b0, 5'd19, 20'h0,     1, 1, 3'd3, 20'h80000, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[7]  = mk(1'b0, 5'd4,  20'h0,     0, 1, 3'd4, 20'h00010, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[8]  = mk(1'b0, 5'd8,  20'h0,     1, 1, 3'd4, 20'h00100, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[9]  = mk(1'b0, 5'd8,  20'h0,     0, 1, 3'd1, 20'h00100, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[10] = mk(1'b1, 5'd5,  20'h80001, 0, 2, 3'd1, 20'h80000, 3'd2, 20'h00001, 3'd0, 20'h0, 3'd0, 20'h0);
        vecs[11] = mk(1'b0, 5'd5,  20'hFFFFF, 0, 1, 3'd0, 20'h00020, 3'd0, 20'h0, 3'd0, 20'h0, 3'd0, 20'h0);

        rst = 1'b1;
        idle_in();
        set_ready(1'b1);
        if_xy.in_um_type = 1'b0; if_xy.in_addr0 = '0; if_xy.in_addr1 = '0;
        if_yx.in_um_type = 1'b0; if_yx.in_addr0 = '0; if_yx.in_addr1 = '0;

        repeat (2) @(negedge clk);
        o = samp(0);
        chk("rst_inready", 32'(o.rdy), 32'd0);
        chk("rst_valid", 32'(o.v), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = samp(s);
            chk($sformatf("post_rst%0d_ready", s), 32'(o.rdy), 32'd1);
            chk($sformatf("post_rst%0d_valid", s), 32'(o.v), 32'd0);
            chk($sformatf("post_rst%0d_port", s), 32'(o.p), 32'd0);
            chk($sformatf("post_rst%0d_dests", s), 32'(o.d), 32'd0);
            chk($sformatf("post_rst%0d_um_last_err", s), {29'd0, o.um, o.last, o.err}, 32'd0);
        end

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Backpressure on beat 2 of the four-beat multicast.
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        idle_in();
        o = samp(0);
        chk("bp_b0_port", 32'(o.p), 32'd0);
        @(negedge clk);
        set_ready(1'b0);
        for (int k = 0; k < 3; k++) begin
            o = samp(0);
            $display("bp hold%0d port=%0d dests=0x%05h", k, o.p, o.d);
            chk($sformatf("bp_hold%0d_valid", k), 32'(o.v), 32'd1);
            chk($sformatf("bp_hold%0d_port", k), 32'(o.p), 32'd1);
            chk($sformatf("bp_hold%0d_dests", k), 32'(o.d), 32'h02000);
            chk($sformatf("bp_hold%0d_last", k), 32'(o.last), 32'd0);
            @(negedge clk);
        end
        set_ready(1'b1);
        o = samp(0);
        chk("bp_b1_port", 32'(o.p), 32'd1);
        @(negedge clk);
        o = samp(0);
        chk("bp_b2_beat", {o.p, o.d, o.last}, {3'd2, 20'h00004, 1'b0});
        @(negedge clk);
        o = samp(0);
        chk("bp_b3_beat", {o.p, o.d, o.last}, {3'd3, 20'h00040, 1'b1});
        @(negedge clk);
        o = samp(0);
        chk("bp_done", {o.v, o.rdy}, 2'b01);

        // Reset asserted while beat 2 is presented.
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        idle_in();
        o = samp(0);
        chk("rm_b0_port", 32'(o.p), 32'd0);
        @(negedge clk);
        o = samp(0);
        chk("rm_b1_port", 32'(o.p), 32'd1);
        rst = 1'b1;
        #1;
        o = samp(0);
        chk("rm_during_valid", 32'(o.v), 32'd0);
        chk("rm_during_ready", 32'(o.rdy), 32'd0);
        @(negedge clk);
        o = samp(0);
        chk("rm_after_outs", {o.v, o.p, o.d, o.um, o.last, o.err}, 28'd0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o = samp(0);
            chk($sformatf("rm_stale%0d", k), {o.v, o.rdy, o.d}, {1'b0, 1'b1, 20'h0});
        end
        run_vec(20, vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/mc_route_split.md
# mc_route_split

Parametrised route-compute and multicast-split stage for one router input port of the X×Y mesh. A head flit carries either a unicast binary node address or a multicast one-hot destination vector. The block groups all destinations by output port under XY or YX dimension-order routing. It then emits one route beat per non-empty output port, each carrying only the destinations reachable through that port. This gives tree-based multicast in place of the single-next-hop chain used for multicast today. The block sits between the input VC buffer head and the switch allocator and uses valid/ready handshakes on both sides.

## Interface
- XSIZE, 5, mesh columns (x coordinate 0..XSIZE-1)
- YSIZE, 4, mesh rows (y coordinate 0..YSIZE-1)
- MY_XPOS, 0, this router's x
- MY_YPOS, 0, this router's y
- ROUTING, 0, 0 = XY dimension order, 1 = YX dimension order
- NODES, XSIZE*YSIZE, derived, not overridden; node index = x*YSIZE + y
- AW, clog2(NODES), derived width of the unicast address
- clk  in  1  clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  head flit route request present
- in_ready  out  1  block accepts a request this cycle
- in_um_type  in  1  0 = unicast, 1 = multicast
- in_addr0  in  AW  unicast destination node index
- in_addr1  in  NODES  multicast one-hot destination vector
- out_valid  out  1  route beat valid
- out_ready  in  1  allocator consumes the beat
- out_port  out  3  0 Local, 1 East (+x), 2 West (−x), 3 North (+y), 4 South (−y)
- out_dests  out  NODES  destination subset for this beat
- out_um_type  out  1  copy of the captured in_um_type
- out_last  out  1  final beat of the current request
- out_err  out  1  one-cycle pulse when a request has no valid destination

## Operation
- Per-node port table is fixed at elaboration. For XY routing, a destination with dx≠MY_XPOS goes East if dx>MY_XPOS, otherwise West. A destination with dx=MY_XPOS and dy≠MY_YPOS goes North if dy>MY_YPOS, otherwise South. The node equal to MY_POS goes Local. YX routing is the same rule with the y axis tested first.
- Unicast requests are converted to a one-hot mask: bit in_addr0 is set if in_addr0<NODES, otherwise the mask is zero. Both request types then share one path. in_addr0 is ignored for multicast; in_addr1 is ignored for unicast.
- On accept, the five per-port masks (Local, East, West, North, South) are registered. Each mask is the input mask ANDed with the table for that port.
- FSM has two states, IDLE and EMIT.
  - IDLE: in_ready=1. On in_valid, capture the request and go to EMIT. If the mask is all zero, instead pulse out_err for one cycle and stay in IDLE.
  - EMIT: present the lowest-numbered non-empty port group. On out_valid&&out_ready, clear that group. If it was the last non-empty group, go to IDLE. Otherwise present the next group in the following cycle.
- out_last=1 exactly when the presented group is the only remaining non-empty group.
- out_port, out_dests and out_um_type are stable while out_valid=1 and out_ready=0.
- The union of out_dests over all beats equals the captured mask. Beats are disjoint.

## Timing
- While rst=1 and in the cycle after reset: state IDLE, out_valid=0, out_port=0, out_dests=0, out_um_type=0, out_last=0, out_err=0, all masks 0.
- in_ready=0 while rst=1.
- Rst asserted in EMIT abandons the remaining beats. No beat may follow reset.
- A request accepted at edge N gives out_valid=1 in cycle N+1, so latency is 1 cycle.
- Beats with out_ready held high are back-to-back with no bubbles.
- in_ready=0 throughout EMIT. in_ready returns to 1 in the cycle after the last beat's handshake.
- A k-beat request therefore occupies k+1 cycles at best.
- out_err is asserted in cycle N+1 for a zero mask accepted at N. out_valid stays 0 in that case.
- No combinational path from in_* to out_*. in_ready depends on state only.

## Test plan
- Multicast XY, 5×4, node (1,1), MY_POS=5, in_addr1=0x2064 (bits 2, 5, 6, 13), out_ready=1 -> four consecutive beats: (port 0, 0x00020), (1, 0x02000), (2, 0x00004), (3, 0x00040). out_last only on the fourth beat. in_ready=1 again on cycle 6.
- Same stimulus with ROUTING=1 -> three beats: (0, 0x20), (1, 0x2000), (3, 0x44). Node 2 moves to the North group.
- Unicast in_addr0=19 at node (1,1) -> one beat, port 1, out_dests=0x80000, out_last=1, out_um_type=0. Unicast in_addr0=5 -> port 0, out_dests=0x20.
- Zero-destination cases: unicast in_addr0=20, or multicast in_addr1=0 -> out_err pulse in the next cycle, no out_valid, in_ready stays 1.
- Backpressure: from the first test's stimulus, hold out_ready=0 for 3 cycles on beat 2 -> out_port=1 and out_dests=0x2000 held stable. The remaining beats follow once out_ready=1.
- Reset mid-operation: assert rst during beat 2 -> out_valid=0 next cycle and all outputs at reset values. A new unicast after reset routes correctly with no stale beats.
